// File: rtl/iomem_initiator.sv
// iomem_initiator
// ---------------
// Bus-master adapter for the SoC iomem peripheral bus. A non-CPU agent
// issues one command (single beat or incrementing-address burst) and gets
// back one response per beat. Write bursts repeat the same data word, which
// makes them fill operations. Each beat has a ready timeout, so a dead
// peripheral cannot hang the agent.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A valid source holds its payload stable until that edge, and it never
// withdraws valid early. This applies to cmd_*, rsp_* and iomem_*. On the
// iomem side, iomem_ready plays the role of ready.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_addr/wdata/wstrb/count   command payload (wstrb==0 -> read,
//                                count = beats-1)
//   rsp_valid/rsp_ready          per-beat response handshake
//   rsp_rdata/rsp_err/rsp_last   response payload
//   busy                         high while a command is in flight
//   iomem_*                      peripheral bus master side
//   fsm_state                    debug view of the FSM state
//                                (0 IDLE, 1 BUS, 2 RSP)
module iomem_initiator #(
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,
    input  logic [LEN_W-1:0] cmd_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             rsp_last,
    output logic             busy,
    output logic             iomem_valid,
    input  logic             iomem_ready,
    output logic [3:0]       iomem_wstrb,
    output logic [31:0]      iomem_addr,
    output logic [31:0]      iomem_wdata,
    input  logic [31:0]      iomem_rdata,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // The counter only has to reach TIMEOUT_CYCLES-1. With the timeout
    // disabled (0), the counter wraps freely and nobody looks at it.
    localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [LEN_W-1:0] beat;
    logic [LEN_W-1:0] count;
    logic             timeout_hit;
    logic             addr_lo_unused;

    // Sub-word address bits carry no meaning on this bus.
    assign addr_lo_unused = ^cmd_addr[1:0];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign iomem_valid = (state == BUS);
    assign rsp_valid   = (state == RSP);
    // beat==count is also true in IDLE after reset, so qualify with RSP.
    assign rsp_last    = (state == RSP) && (rsp_err || (beat == count));
    assign fsm_state   = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) state_nxt = BUS;
            // Ready is tested first, so it wins over a same-cycle timeout.
            BUS:  if (iomem_ready || timeout_hit) state_nxt = RSP;
            RSP:  if (rsp_ready) state_nxt = rsp_last ? IDLE : BUS;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            iomem_wstrb <= '0;
            count       <= '0;
            beat        <= '0;
            to_cnt      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        iomem_addr  <= {cmd_addr[31:2], 2'b00};
                        iomem_wdata <= cmd_wdata;
                        iomem_wstrb <= cmd_wstrb;
                        count       <= cmd_count;
                        beat        <= '0;
                        to_cnt      <= '0;
                    end
                end
                BUS: begin
                    if (iomem_ready) begin
                        rsp_rdata <= (iomem_wstrb == 4'b0000) ? iomem_rdata : 32'h0;
                        rsp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready && !rsp_last) begin
                        iomem_addr <= iomem_addr + 32'd4;
                        beat       <= beat + 1'b1;
                        to_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed and randomized checks of iomem_initiator. The bench acts as the
// bus peripheral and as the response consumer. Expected beat addresses,
// data and response fields come from the command itself.
module tb_iomem_initiator;

    localparam int unsigned LEN_W = 8;
    localparam int          TO    = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_addr = '0;
    logic [31:0]      cmd_wdata = '0;
    logic [3:0]       cmd_wstrb = '0;
    logic [LEN_W-1:0] cmd_count = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             rsp_last;
    logic             busy;
    logic             iomem_valid;
    logic             iomem_ready = 1'b0;
    logic [3:0]       iomem_wstrb;
    logic [31:0]      iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata = '0;
    logic [1:0]       fsm_state_mon;

    int vectors = 0;
    int miscompares = 0;

    iomem_initiator #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .cmd_count   (cmd_count),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_last    (rsp_last),
        .busy        (busy),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .fsm_state   (fsm_state_mon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one command at a negedge and follows it to completion, one
    // cycle per step. The bench checks all outputs on every negedge.
    //   wait_fix >= 0 : ready comes after that many wait cycles on every beat
    //   wait_fix <  0 : random 0..6 wait cycles per beat
    //   to_beat       : index of the beat that never gets ready (-1 = none)
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int cnt, input int wait_fix, input int to_beat,
                           input bit rsp_rand, input bit rd_fix, input logic [31:0] rd_val);
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        logic [31:0] drv_rd;
        bit          exp_err;
        bit          exp_last;
        bit          rdy;
        bit          rr;
        int          v;
        int          h;
        int          w;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_count = LEN_W'(cnt);
        @(negedge clk);
        // Scramble the command fields so that unlatched use shows up.
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
        cmd_count = LEN_W'($urandom);
        for (int b = 0; b <= cnt; b++) begin
            exp_addr = (a & 32'hFFFF_FFFC) + 32'(4 * b);
            w        = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 6));
            v        = 0;
            exp_err  = 1'b0;
            exp_rd   = 32'h0;
            forever begin
                chk("bus_iomem_valid", 32'(iomem_valid), 32'd1);
                chk("bus_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("bus_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("bus_busy", 32'(busy), 32'd1);
                chk("bus_addr", iomem_addr, exp_addr);
                chk("bus_wdata", iomem_wdata, wd);
                chk("bus_wstrb", 32'(iomem_wstrb), 32'(ws));
                rdy         = (b != to_beat) && (v == w);
                drv_rd      = (rd_fix && rdy) ? rd_val : $urandom;
                iomem_ready = rdy;
                iomem_rdata = drv_rd;
                @(negedge clk);
                v++;
                if (rdy) begin
                    exp_rd = (ws == 4'b0000) ? drv_rd : 32'h0;
                    break;
                end
                if (v == TO) begin
                    exp_err = 1'b1;
                    break;
                end
            end
            iomem_ready = 1'b0;
            iomem_rdata = $urandom;
            exp_last    = exp_err || (b == cnt);
            h           = 0;
            forever begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_iomem_valid", 32'(iomem_valid), 32'd0);
                chk("rsp_busy", 32'(busy), 32'd1);
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
                chk("rsp_last", 32'(rsp_last), 32'(exp_last));
                rr        = (!rsp_rand || h >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                rsp_ready = rr;
                @(negedge clk);
                h++;
                if (rr) break;
            end
            rsp_ready = 1'b0;
            if (exp_err) break;
        end
        chk("end_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_iomem_valid", 32'(iomem_valid), 32'd0);
        chk("end_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rw;
        logic [3:0]  rs;
        int          rc;
        int          tb_beat;

        // Reset state
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_iomem_valid", 32'(iomem_valid), 32'd0);
        chk("rst_addr", iomem_addr, 32'h0);
        chk("rst_wdata", iomem_wdata, 32'h0);
        chk("rst_wstrb", 32'(iomem_wstrb), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Single write, zero-wait peripheral, rsp_ready always high
        run_cmd(32'h0300_0000, 32'h1234_5678, 4'hF, 0, 0, -1, 1'b0, 1'b0, 32'h0);
        // Single read with 3 wait cycles
        run_cmd(32'h0700_0004, 32'h0, 4'h0, 0, 3, -1, 1'b0, 1'b1, 32'hCAFE_F00D);
        // Read burst with a toggling consumer
        run_cmd(32'h0600_0000, 32'h0, 4'h0, 3, 0, -1, 1'b1, 1'b0, 32'h0);
        // Write fill across the top of the address space
        run_cmd(32'hFFFF_FFF8, 32'hA5A5_5A5A, 4'hF, 2, -1, -1, 1'b0, 1'b0, 32'h0);
        // Dead peripheral: first beat times out, burst aborted
        run_cmd(32'h0400_0010, 32'h0, 4'h0, 5, 0, 0, 1'b0, 1'b0, 32'h0);
        // Timeout in the middle of a write burst
        run_cmd(32'h0500_0000, 32'h0BAD_BEEF, 4'h3, 4, 1, 2, 1'b1, 1'b0, 32'h0);

        // Asynchronous reset while in BUS
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0500_0000;
        cmd_wstrb = 4'h0;
        cmd_count = LEN_W'(3);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_bus_iomem_valid", 32'(iomem_valid), 32'd0);
        chk("arst_bus_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_bus_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_bus_busy", 32'(busy), 32'd0);
        chk("arst_bus_addr", iomem_addr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_cmd(32'h0200_0008, 32'h0, 4'h0, 1, 0, -1, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset while in RSP
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0100_0000;
        cmd_wstrb = 4'h0;
        cmd_count = LEN_W'(0);
        @(negedge clk);
        cmd_valid   = 1'b0;
        iomem_ready = 1'b1;
        iomem_rdata = 32'hDEAD_0001;
        @(negedge clk);
        iomem_ready = 1'b0;
        chk("pre_arst_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_rsp_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_rsp_last", 32'(rsp_last), 32'd0);
        chk("arst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_cmd(32'h0300_0100, 32'h5555_AAAA, 4'hC, 2, 0, -1, 1'b0, 1'b0, 32'h0);

        // Randomized commands
        for (int i = 0; i < 24; i++) begin
            ra      = $urandom;
            rw      = $urandom;
            rs      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rc      = int'($urandom_range(0, 5));
            tb_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rc)) : -1;
            run_cmd(ra, rw, rs, rc, -1, tb_beat, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
